// File: rtl/configure.sv
// Shared configuration for the AXI line-burst adapter.
// Holds the FSM state encoding and the default burst length.
package configure;

   localparam int BEATS_DEFAULT = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WRITE,
      RESP,
      DONE
   } state_t;

endpackage

// File: rtl/axi_burst.sv
// Turns one cache-line request into a single AXI4 INCR burst.
// Ports: line-side request (axi_*), AXI4 master channels (m_axi_*).
module axi_burst
   import configure::*;
#(
   parameter int BEATS = BEATS_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 axi_valid,
   input  logic                 axi_instr,
   input  logic [31:0]          axi_addr,
   input  logic [32*BEATS-1:0]  axi_wdata,
   input  logic [4*BEATS-1:0]   axi_wstrb,
   output logic [32*BEATS-1:0]  axi_rdata,
   output logic                 axi_ready,
   output logic                 axi_error,
   output logic [31:0]          m_axi_awaddr,
   output logic [7:0]           m_axi_awlen,
   output logic [1:0]           m_axi_awburst,
   output logic [2:0]           m_axi_awprot,
   output logic                 m_axi_awvalid,
   input  logic                 m_axi_awready,
   output logic [31:0]          m_axi_wdata,
   output logic [3:0]           m_axi_wstrb,
   output logic                 m_axi_wlast,
   output logic                 m_axi_wvalid,
   input  logic                 m_axi_wready,
   input  logic [1:0]           m_axi_bresp,
   input  logic                 m_axi_bvalid,
   output logic                 m_axi_bready,
   output logic [31:0]          m_axi_araddr,
   output logic [7:0]           m_axi_arlen,
   output logic [1:0]           m_axi_arburst,
   output logic [2:0]           m_axi_arprot,
   output logic                 m_axi_arvalid,
   input  logic                 m_axi_arready,
   input  logic [31:0]          m_axi_rdata,
   input  logic [1:0]           m_axi_rresp,
   input  logic                 m_axi_rlast,
   input  logic                 m_axi_rvalid,
   output logic                 m_axi_rready
);

   localparam int LB = BEATS * 4;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   state_t state, state_nx;

   logic [31:0]         addr_q;
   logic                instr_q;
   logic [32*BEATS-1:0] wdata_q;
   logic [4*BEATS-1:0]  wstrb_q;
   logic [32*BEATS-1:0] line_q;
   logic [32*BEATS-1:0] line_nx;
   logic [32*BEATS-1:0] rdata_q;
   logic [CW-1:0]       cnt;
   logic                err;
   logic                aw_done;
   logic                w_done;
   logic                ar_done;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_awlen   = 8'(BEATS - 1);
   assign m_axi_arlen   = 8'(BEATS - 1);
   assign m_axi_awburst = 2'b01;
   assign m_axi_arburst = 2'b01;
   assign m_axi_awprot  = {instr_q, 2'b00};
   assign m_axi_arprot  = {instr_q, 2'b00};
   assign m_axi_wdata   = wdata_q[32*int'(cnt) +: 32];
   assign m_axi_wstrb   = wstrb_q[4*int'(cnt) +: 4];
   assign m_axi_wlast   = (cnt == LAST);
   assign axi_rdata     = rdata_q;

   // Line with the current read beat merged in, so the
   // published line can be updated on the final beat itself.
   always_comb begin
      line_nx = line_q;
      line_nx[32*int'(cnt) +: 32] = m_axi_rdata;
   end

   always_comb begin
      state_nx      = state;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      axi_ready     = 1'b0;
      axi_error     = 1'b0;
      unique case (state)
         IDLE: begin
            if (axi_valid)
               state_nx = (axi_wstrb == '0) ? READ : WRITE;
         end
         READ: begin
            m_axi_arvalid = !ar_done;
            m_axi_rready  = 1'b1;
            if (m_axi_rvalid && m_axi_rlast)
               state_nx = DONE;
         end
         WRITE: begin
            m_axi_awvalid = !aw_done;
            m_axi_wvalid  = !w_done;
            // AW and the last W may finish in either order or together.
            if ((aw_done || m_axi_awready) &&
                (w_done || (m_axi_wready && cnt == LAST)))
               state_nx = RESP;
         end
         RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid)
               state_nx = DONE;
         end
         DONE: begin
            axi_ready = 1'b1;
            axi_error = err;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         instr_q <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         line_q  <= '0;
         rdata_q <= '0;
         cnt     <= '0;
         err     <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         ar_done <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (axi_valid) begin
                  addr_q  <= axi_addr & ~32'(LB - 1);
                  instr_q <= axi_instr;
                  wdata_q <= axi_wdata;
                  wstrb_q <= axi_wstrb;
                  cnt     <= '0;
                  err     <= 1'b0;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  ar_done <= 1'b0;
               end
            end
            READ: begin
               if (!ar_done && m_axi_arready)
                  ar_done <= 1'b1;
               if (m_axi_rvalid) begin
                  line_q <= line_nx;
                  // Surplus beats keep landing in the last slot.
                  if (cnt != LAST)
                     cnt <= cnt + 1'b1;
                  if (m_axi_rresp != 2'b00)
                     err <= 1'b1;
                  if (m_axi_rlast)
                     rdata_q <= line_nx;
               end
            end
            WRITE: begin
               if (!aw_done && m_axi_awready)
                  aw_done <= 1'b1;
               if (!w_done && m_axi_wready) begin
                  if (cnt == LAST)
                     w_done <= 1'b1;
                  else
                     cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               if (m_axi_bvalid)
                  err <= (m_axi_bresp != 2'b00);
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_burst.sv
// Scoreboard bench for axi_burst: random line reads and writes
// against a bus-level slave model, plus reset and single-beat cases.
module tb_axi_burst;
   import configure::*;

   localparam int B = 4;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   logic              axi_valid = 0;
   logic              axi_instr = 0;
   logic [31:0]       axi_addr = 0;
   logic [32*B-1:0]   axi_wdata = 0;
   logic [4*B-1:0]    axi_wstrb = 0;
   logic [32*B-1:0]   axi_rdata;
   logic              axi_ready, axi_error;
   logic [31:0]       m_axi_awaddr, m_axi_araddr, m_axi_wdata;
   logic [7:0]        m_axi_awlen, m_axi_arlen;
   logic [1:0]        m_axi_awburst, m_axi_arburst;
   logic [2:0]        m_axi_awprot, m_axi_arprot;
   logic [3:0]        m_axi_wstrb;
   logic              m_axi_awvalid, m_axi_wvalid, m_axi_wlast;
   logic              m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic              m_axi_awready = 0, m_axi_wready = 0;
   logic              m_axi_bvalid = 0, m_axi_arready = 0;
   logic              m_axi_rvalid = 0, m_axi_rlast = 0;
   logic [1:0]        m_axi_bresp = 0, m_axi_rresp = 0;
   logic [31:0]       m_axi_rdata = 0;

   axi_burst #(.BEATS(B)) dut (
      .clock(clock), .reset(reset),
      .axi_valid(axi_valid), .axi_instr(axi_instr),
      .axi_addr(axi_addr), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_rdata(axi_rdata),
      .axi_ready(axi_ready), .axi_error(axi_error),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awburst(m_axi_awburst), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   // Single-beat instance
   logic        v1 = 0;
   logic [31:0] a1 = 0, wd1 = 0;
   logic [3:0]  ws1 = 0;
   logic [31:0] rd1, awaddr1, araddr1, wdata1;
   logic        rdy1, err1;
   logic [7:0]  awlen1, arlen1;
   logic [1:0]  awburst1, arburst1;
   logic [2:0]  awprot1, arprot1;
   logic [3:0]  wstrb1;
   logic        awvalid1, wvalid1, wlast1, bready1, arvalid1, rready1;
   logic        bvalid1 = 0;

   axi_burst #(.BEATS(1)) dut1 (
      .clock(clock), .reset(reset),
      .axi_valid(v1), .axi_instr(1'b1),
      .axi_addr(a1), .axi_wdata(wd1),
      .axi_wstrb(ws1), .axi_rdata(rd1),
      .axi_ready(rdy1), .axi_error(err1),
      .m_axi_awaddr(awaddr1), .m_axi_awlen(awlen1),
      .m_axi_awburst(awburst1), .m_axi_awprot(awprot1),
      .m_axi_awvalid(awvalid1), .m_axi_awready(1'b1),
      .m_axi_wdata(wdata1), .m_axi_wstrb(wstrb1),
      .m_axi_wlast(wlast1), .m_axi_wvalid(wvalid1),
      .m_axi_wready(1'b1), .m_axi_bresp(2'b00),
      .m_axi_bvalid(bvalid1), .m_axi_bready(bready1),
      .m_axi_araddr(araddr1), .m_axi_arlen(arlen1),
      .m_axi_arburst(arburst1), .m_axi_arprot(arprot1),
      .m_axi_arvalid(arvalid1), .m_axi_arready(1'b0),
      .m_axi_rdata(32'h0), .m_axi_rresp(2'b00),
      .m_axi_rlast(1'b0), .m_axi_rvalid(1'b0),
      .m_axi_rready(rready1)
   );

   typedef struct {
      logic          rd;
      logic          instr;
      logic [31:0]   addr;
      logic [127:0]  wdata;
      logic [15:0]   wstrb;
      logic [127:0]  rline;
      logic [7:0]    rresp;
      logic [1:0]    bresp;
      int            ard;
      int            awd;
      int            wg0;
   } tx_t;

   typedef struct {
      logic          err;
      logic [127:0]  line;
   } exp_t;

   tx_t  slq[$];
   exp_t expq[$];
   logic [127:0] last_line = '0;
   int   hs_cyc = -1;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] line_base(input logic [31:0] a);
      return a - (a % 32'(4 * B));
   endfunction

   function automatic tx_t rand_tx();
      tx_t t;
      t.rd    = 1'($urandom_range(0, 1));
      t.instr = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      t.wdata = {$urandom, $urandom, $urandom, $urandom};
      t.rline = {$urandom, $urandom, $urandom, $urandom};
      t.wstrb = 16'($urandom_range(1, 16'hFFFF));
      t.rresp = '0;
      for (int i = 0; i < B; i++)
         if ($urandom_range(0, 7) == 0)
            t.rresp[2*i +: 2] = 2'($urandom_range(1, 3));
      t.bresp = ($urandom_range(0, 3) == 0) ?
                2'($urandom_range(1, 3)) : 2'b00;
      t.ard = $urandom_range(0, 3);
      t.awd = $urandom_range(0, 6);
      t.wg0 = $urandom_range(0, 2);
      return t;
   endfunction

   // Slave side: AR then R beats.
   task automatic do_read(input tx_t t);
      int d = t.ard;
      forever begin
         chk("arvalid_hold", m_axi_arvalid, 1'b1);
         m_axi_arready = (d == 0);
         if (d == 0) begin
            chk("araddr", m_axi_araddr, line_base(t.addr));
            chk("arlen", m_axi_arlen, 8'(B - 1));
            chk("arburst", m_axi_arburst, 2'b01);
            chk("arprot", m_axi_arprot, {t.instr, 2'b00});
         end
         @(posedge clock); #1;
         if (d == 0) break;
         d--;
      end
      m_axi_arready = 0;
      chk("arvalid_drop", m_axi_arvalid, 1'b0);
      for (int i = 0; i < B; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
         end
         m_axi_rvalid = 1;
         m_axi_rdata  = t.rline[32*i +: 32];
         m_axi_rresp  = t.rresp[2*i +: 2];
         m_axi_rlast  = (i == B - 1);
         chk("rready", m_axi_rready, 1'b1);
         @(posedge clock); #1;
         m_axi_rvalid = 0;
         m_axi_rlast  = 0;
      end
      hs_cyc = cyc;
   endtask

   // Slave side: AW and W run independently, then B.
   task automatic do_write(input tx_t t);
      int  awd = t.awd;
      int  wg  = t.wg0;
      int  nb  = 0;
      int  g   = 0;
      bit  aw_got = 0;
      bit  h_aw, h_w;
      while (!(aw_got && nb == B) && g < 200) begin
         g++;
         m_axi_awready = !aw_got && awd == 0;
         m_axi_wready  = nb < B && wg == 0;
         chk("awvalid", m_axi_awvalid, !aw_got);
         chk("wvalid", m_axi_wvalid, nb < B);
         chk("bready_early", m_axi_bready, 1'b0);
         h_aw = m_axi_awready && m_axi_awvalid;
         h_w  = m_axi_wready && m_axi_wvalid;
         if (h_aw) begin
            chk("awaddr", m_axi_awaddr, line_base(t.addr));
            chk("awlen", m_axi_awlen, 8'(B - 1));
            chk("awburst", m_axi_awburst, 2'b01);
            chk("awprot", m_axi_awprot, {t.instr, 2'b00});
         end
         if (h_w) begin
            chk("wdata", m_axi_wdata, t.wdata[32*nb +: 32]);
            chk("wstrb", m_axi_wstrb, t.wstrb[4*nb +: 4]);
            chk("wlast", m_axi_wlast, nb == B - 1);
         end
         @(posedge clock); #1;
         if (h_aw) aw_got = 1;
         else if (awd > 0) awd--;
         if (h_w) begin
            nb++;
            wg = $urandom_range(0, 1);
         end else if (wg > 0) wg--;
      end
      m_axi_awready = 0;
      m_axi_wready  = 0;
      chk("aw_w_complete", g < 200, 1'b1);
      repeat ($urandom_range(0, 2)) begin
         chk("bready_wait", m_axi_bready, 1'b1);
         @(posedge clock); #1;
      end
      m_axi_bvalid = 1;
      m_axi_bresp  = t.bresp;
      chk("bready", m_axi_bready, 1'b1);
      @(posedge clock); #1;
      m_axi_bvalid = 0;
      m_axi_bresp  = 0;
      hs_cyc = cyc;
   endtask

   initial begin
      tx_t t;
      forever begin
         @(posedge clock); #1;
         if (!reset && slq.size() != 0 &&
             (m_axi_arvalid || m_axi_awvalid)) begin
            t = slq.pop_front();
            chk("kind", m_axi_arvalid, t.rd);
            if (t.rd) do_read(t);
            else do_write(t);
         end
      end
   end

   // Monitor: every completion pulse is matched to the scoreboard.
   always @(negedge clock) begin
      if (!reset && axi_ready) begin
         if (expq.size() == 0) begin
            chk("unexpected_ready", axi_ready, 1'b0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("axi_error", axi_error, e.err);
            chk("axi_rdata", axi_rdata, e.line);
            chk("latency", 32'(cyc), 32'(hs_cyc));
         end
      end
   end

   task automatic issue(input tx_t t);
      exp_t e;
      int   g = 0;
      if (t.rd) begin
         e.err = 0;
         for (int i = 0; i < B; i++)
            if (t.rresp[2*i +: 2] != 0) e.err = 1;
         e.line = t.rline;
         last_line = t.rline;
      end else begin
         e.err  = (t.bresp != 0);
         e.line = last_line;
      end
      slq.push_back(t);
      expq.push_back(e);
      axi_valid = 1;
      axi_instr = t.instr;
      axi_addr  = t.addr;
      axi_wdata = t.wdata;
      axi_wstrb = t.rd ? '0 : t.wstrb;
      @(posedge clock); #1;
      while (expq.size() != 0) begin
         if (g++ > 400) begin
            $display("FAIL timeout: got %0d pending want 0", expq.size());
            n_bad++;
            $fatal(1, "no completion");
         end
         // Noise on the request side must be ignored while busy.
         axi_valid = 1'($urandom_range(0, 1));
         axi_addr  = $urandom;
         axi_wstrb = 16'($urandom);
         @(posedge clock); #1;
      end
      axi_valid = 0;
   endtask

   initial begin
      tx_t t;
      #2 reset = 1;
      #1;
      chk("rst_ready", axi_ready, 1'b0);
      chk("rst_error", axi_error, 1'b0);
      chk("rst_arvalid", m_axi_arvalid, 1'b0);
      chk("rst_awvalid", m_axi_awvalid, 1'b0);
      chk("rst_wvalid", m_axi_wvalid, 1'b0);
      chk("rst_rready", m_axi_rready, 1'b0);
      chk("rst_bready", m_axi_bready, 1'b0);
      chk("rst_rdata", axi_rdata, '0);
      repeat (2) @(posedge clock);
      #1 reset = 0;
      @(posedge clock); #1;

      t = rand_tx();
      t.rd = 1; t.addr = 32'h104; t.ard = 3; t.rresp = '0;
      t.rline = {32'h44, 32'h33, 32'h22, 32'h11};
      issue(t);

      t = rand_tx();
      t.rd = 0; t.wg0 = 2; t.awd = 14; t.bresp = 0;
      issue(t);

      t = rand_tx();
      t.rd = 1; t.rresp = 8'b0000_1000;
      issue(t);
      t = rand_tx();
      t.rd = 1; t.rresp = '0;
      issue(t);

      for (int n = 0; n < 40; n++) begin
         t = rand_tx();
         issue(t);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end

      // Reset in the middle of a read burst.
      axi_valid = 1; axi_addr = 32'h200; axi_wstrb = '0;
      @(posedge clock); #1;
      axi_valid = 0; m_axi_arready = 1;
      @(posedge clock); #1;
      m_axi_arready = 0;
      m_axi_rvalid = 1; m_axi_rdata = 32'hAA; m_axi_rresp = 0;
      @(posedge clock); #1;
      m_axi_rdata = 32'hBB;
      @(posedge clock); #1;
      m_axi_rvalid = 0;
      chk("mid_cnt", 32'(dut.cnt), 32'd2);
      chk("mid_rready", m_axi_rready, 1'b1);
      #2 reset = 1;
      #1;
      chk("ar_rst_arvalid", m_axi_arvalid, 1'b0);
      chk("ar_rst_rready", m_axi_rready, 1'b0);
      chk("ar_rst_cnt", 32'(dut.cnt), 32'd0);
      chk("ar_rst_idle", dut.state == IDLE, 1'b1);
      chk("ar_rst_rdata", axi_rdata, '0);
      @(posedge clock); #1;
      reset = 0;
      last_line = '0;
      @(posedge clock); #1;
      t = rand_tx();
      t.rd = 0;
      issue(t);
      t = rand_tx();
      t.rd = 1;
      issue(t);

      // Single-beat write.
      v1 = 1; a1 = 32'h37; wd1 = 32'hCAFEBABE; ws1 = 4'hF;
      @(posedge clock); #1;
      v1 = 0;
      chk("b1_awvalid", awvalid1, 1'b1);
      chk("b1_awlen", awlen1, 8'd0);
      chk("b1_awaddr", awaddr1, 32'h34);
      chk("b1_awprot", awprot1, 3'b100);
      chk("b1_wvalid", wvalid1, 1'b1);
      chk("b1_wlast", wlast1, 1'b1);
      chk("b1_wdata", wdata1, 32'hCAFEBABE);
      chk("b1_bready_early", bready1, 1'b0);
      @(posedge clock); #1;
      chk("b1_bready", bready1, 1'b1);
      chk("b1_wvalid_drop", wvalid1, 1'b0);
      chk("b1_awvalid_drop", awvalid1, 1'b0);
      bvalid1 = 1;
      @(posedge clock); #1;
      bvalid1 = 0;
      chk("b1_ready", rdy1, 1'b1);
      chk("b1_error", err1, 1'b0);
      @(posedge clock); #1;
      chk("b1_ready_pulse", rdy1, 1'b0);

      repeat (3) @(posedge clock);
      chk("scoreboard_empty", 32'(expq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_burst.md
AXI_BURST -- requirements
Module: axi_burst
Interface
REQ-001 BEATS, 4, beats per burst (1,2,4,8,16); line size LB = BEATS*4 bytes.
REQ-002 reset  in  1  asynchronous, active-high.
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 axi_valid  in  1  request strobe, sampled only in IDLE.
REQ-005 axi_instr  in  1  instruction fetch; drives prot[2].
REQ-006 axi_addr  in  32  byte address, aligned down to LB.
REQ-007 axi_wdata  in  32*BEATS  line write data, beat i = bits [32i+31:32i].
REQ-008 axi_wstrb  in  4*BEATS  line byte strobes; all-zero = read.
REQ-009 axi_rdata  out  32*BEATS  line read data.
REQ-010 axi_ready  out  1  one-cycle completion pulse.
REQ-011 axi_error  out  1  error flag, valid with axi_ready.
REQ-012 m_axi_awaddr  out  32  aligned write address.
REQ-013 m_axi_awlen  out  8  constant BEATS-1.
REQ-014 m_axi_awburst  out  2  constant 2'b01 (INCR).
REQ-015 m_axi_awprot  out  3  {axi_instr,2'b00}.
REQ-016 m_axi_awvalid  out  1  write address valid.
REQ-017 m_axi_awready  in  1  write address ready.
REQ-018 m_axi_wdata  out  32  current write beat.
REQ-019 m_axi_wstrb  out  4  current beat strobes.
REQ-020 m_axi_wlast  out  1  high on beat BEATS-1.
REQ-021 m_axi_wvalid  out  1  write data valid.
REQ-022 m_axi_wready  in  1  write data ready.
REQ-023 m_axi_bresp  in  2  write response.
REQ-024 m_axi_bvalid  in  1  write response valid.
REQ-025 m_axi_bready  out  1  write response ready.
REQ-026 m_axi_araddr  out  32  aligned read address.
REQ-027 m_axi_arlen  out  8  constant BEATS-1.
REQ-028 m_axi_arburst  out  2  constant 2'b01 (INCR).
REQ-029 m_axi_arprot  out  3  {axi_instr,2'b00}.
REQ-030 m_axi_arvalid  out  1  read address valid.
REQ-031 m_axi_arready  in  1  read address ready.
REQ-032 m_axi_rdata  in  32  read beat.
REQ-033 m_axi_rresp  in  2  read response.
REQ-034 m_axi_rlast  in  1  last read beat.
REQ-035 m_axi_rvalid  in  1  read beat valid.
REQ-036 m_axi_rready  out  1  read beat ready.
Function
REQ-037 States IDLE, READ, WRITE, RESP, DONE; in IDLE axi_valid=1 registers addr (aligned), prot, wdata and wstrb, then goes to READ if wstrb all-zero, else WRITE; axi_valid outside IDLE is ignored, and the requester need hold it for one cycle only.
REQ-038 READ: arvalid and rready are high from entry; arvalid stays high until the first arready cycle, then drops; each rvalid&rready stores rdata into slot cnt, cnt+1 saturating at BEATS-1; extra beats overwrite slot BEATS-1; any rresp!=0 sets a sticky error; the rlast handshake goes to DONE.
REQ-039 WRITE: awvalid and wvalid are high from entry; awvalid drops after the awready cycle; each wvalid&wready advances cnt; wlast=(cnt==BEATS-1); after the last beat wvalid drops; when both the AW and all W handshakes are complete (in any order or in the same cycle) go to RESP.
REQ-040 RESP: bready=1; the bvalid cycle sets error=(bresp!=0) and goes to DONE.
REQ-041 DONE lasts one cycle: axi_ready=1 and axi_error=sticky error; the FSM returns to IDLE; latency is one cycle after the rlast or bvalid handshake; a new request is accepted in the following IDLE cycle.
REQ-042 axi_rdata holds the last read line until the next read completes; the error flag and cnt clear on acceptance.
Reset
REQ-043 On reset, the FSM goes to IDLE immediately; all valid and ready outputs, axi_ready, axi_error, cnt and the buffers go to 0; a transfer in flight is abandoned without waiting for the bus.
Structure
REQ-044 The state enum and the BEATS default value live in package configure; there is no sub-module, and the beat counter is inline.
Verification
REQ-045 BEATS=4, read at 0x104, arready delayed 3 cycles, 4 beats with data 0x11..0x44 -> araddr 0x100, arlen 3, axi_rdata={0x44,0x33,0x22,0x11}, one axi_ready pulse with axi_error 0.
REQ-046 Write with wready low for 2 cycles and awready after W completes -> 4 beats, wlast only on the 4th, bready after both handshakes, axi_ready pulse.
REQ-047 Read with rresp=2 on beat 1 -> all beats consumed, axi_ready with axi_error 1; the next read returns axi_error 0.
REQ-048 Reset asserted in READ after 2 beats -> arvalid, rready and cnt go to 0 asynchronously; the FSM is in IDLE, and the next request completes normally.
REQ-049 BEATS=1, write bresp=0 -> awlen 0, wlast on the first beat, completion one cycle after bvalid.
